// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sequences the UART receiver. Generates the 16x oversample
// tick while running, buffers received bytes in a first-word-fall-through
// FIFO, hands them out over valid/ready, and keeps sticky overrun and
// framing error flags.
// Optional build macro: UART_RX_CTRL_STATS_EN adds rx_byte_cnt, a 16-bit
// wrapping count of accepted bytes.
module uart_rx_ctrl #(
  parameter int CLK_DIV    = 27,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  output logic                          rx_tick,
  input  logic                          rx_done,
  input  logic [DATA_W-1:0]             rx_data,
  input  logic                          rx_frame_err,
  output logic [DATA_W-1:0]             m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  output logic                          frame_err,
  input  logic                          clr_err
`ifdef UART_RX_CTRL_STATS_EN
  ,
  output logic [15:0]                   rx_byte_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [15:0]   TICK_LAST = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    RUN      = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [15:0]       tick_cnt;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              fifo_full;
  logic              do_pop;
  logic              do_push;
  logic              set_overrun;
  logic              set_frame;

  // Handshake and push qualification. A full FIFO can still take a byte
  // when the head leaves in the same cycle; nothing is ever overwritten.
  assign m_valid     = (fifo_count != '0);
  assign m_data      = m_valid ? mem[rd_ptr] : '0;
  assign fifo_full   = (fifo_count == DEPTH_C);
  assign do_pop      = m_valid & m_ready;
  assign set_frame   = (state == RUN) & rx_done & rx_frame_err;
  assign do_push     = (state == RUN) & rx_done & ~rx_frame_err & (~fifo_full | do_pop);
  assign set_overrun = (state == RUN) & rx_done & ~rx_frame_err & fifo_full & ~do_pop;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DISABLED;
    else     state <= state_nxt;
  end

  // Next-state decode and tick output; draining keeps the FIFO readable
  // after enable drops until the consumer has emptied it.
  always_comb begin
    state_nxt = state;
    rx_tick   = 1'b0;
    unique case (state)
      DISABLED: begin
        if (en) state_nxt = RUN;
      end
      RUN: begin
        rx_tick = (tick_cnt == TICK_LAST);
        if (!en) state_nxt = (fifo_count != '0) ? DRAIN : DISABLED;
      end
      DRAIN: begin
        if (en)                      state_nxt = RUN;
        else if (fifo_count == '0)   state_nxt = DISABLED;
      end
      default: state_nxt = DISABLED;
    endcase
  end

  // Oversample divider: counts only while staying in RUN, so every entry
  // into RUN starts from 0 and the first tick lands CLK_DIV cycles later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (state == RUN && state_nxt == RUN) begin
      tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 16'd1;
    end else begin
      tick_cnt <= '0;
    end
  end

  // FIFO storage; contents are only meaningful below fifo_count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= rx_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      fifo_count <= fifo_count + CW'(1);
      else if (do_pop && !do_push) fifo_count <= fifo_count - CW'(1);
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= set_overrun | (overrun & ~clr_err);
      frame_err <= set_frame | (frame_err & ~clr_err);
    end
  end

`ifdef UART_RX_CTRL_STATS_EN
  // Accepted-byte statistics, wrapping at 16 bits; cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rx_byte_cnt <= '0;
    else if (do_push) rx_byte_cnt <= rx_byte_cnt + 16'd1;
  end
`endif

endmodule
